// File: rtl/jk_pkg.sv
// Shared types and JK excitation helpers for the JK bank controller.
package jk_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    STROBE = 3'd2,
    SETTLE = 3'd3,
    CHECK  = 3'd4,
    ERROR  = 3'd5
  } jk_state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_TOG  = 2'b11;

  // Returns {J,K}; don't-care entries resolve to 0.
  function automatic logic [1:0] jk_excite(input logic cur, input logic nxt,
                                           input logic use_toggle);
    logic [1:0] r;
    if (cur == nxt)      r = JK_HOLD;
    else if (use_toggle) r = JK_TOG;
    else if (nxt)        r = JK_SET;
    else                 r = JK_RST;
    return r;
  endfunction

endpackage

// File: rtl/jk_excite_ctrl_if.sv
// Target handshake plus JK bank command/readback bundle.
interface jk_excite_ctrl_if #(parameter int WIDTH = 4);
  logic             tgt_valid;
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_ready;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             jk_strobe;
  logic             done;
  logic             err;
  logic             busy;

  modport master (output tgt_valid, tgt_data, q_fb,
                  input  tgt_ready, j, k, jk_strobe, done, err, busy);
  modport slave  (input  tgt_valid, tgt_data, q_fb,
                  output tgt_ready, j, k, jk_strobe, done, err, busy);
endinterface

// File: rtl/jk_excite_bit.sv
// Per-bit JK excitation lookup (combinational).
module jk_excite_bit
  import jk_pkg::*;
#(
  parameter int USE_TOGGLE = 0
) (
  input  logic cur,
  input  logic nxt,
  output logic j,
  output logic k
);

  always_comb {j, k} = jk_excite(cur, nxt, USE_TOGGLE != 0);

endmodule

// File: rtl/jk_excite_ctrl.sv
// Command side of a JK register bank: drives J/K, strobes once, verifies
// the readback, retries up to MAX_RETRY times, then latches an error.
module jk_excite_ctrl
  import jk_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int USE_TOGGLE = 0,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             clr,
  jk_excite_ctrl_if.slave  bus
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);

  jk_state_e        state_q, state_d;
  logic [WIDTH-1:0] tgt_r_q, tgt_r_d;
  logic [2:0]       retry_q, retry_d;
  logic [3:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             accept;
  logic [WIDTH-1:0] exc_nxt, exc_j, exc_k;

  assign accept  = bus.tgt_valid && ready_q && (state_q == IDLE);
  // On the accept cycle the target is not latched yet, so excite from the bus.
  assign exc_nxt = accept ? bus.tgt_data : tgt_r_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_excite_bit #(.USE_TOGGLE(USE_TOGGLE)) u_bit (
      .cur (bus.q_fb[g]),
      .nxt (exc_nxt[g]),
      .j   (exc_j[g]),
      .k   (exc_k[g])
    );
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      tgt_r_q <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_r_q <= tgt_r_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_r_d = tgt_r_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        tgt_r_d = bus.tgt_data;
        retry_d = '0;
        // Already matching: no strobe, one settle cycle against the new target.
        if (bus.q_fb == bus.tgt_data) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LAST;
        end else begin
          state_d = DRIVE;
        end
      end
      DRIVE:  state_d = STROBE;
      STROBE: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      // done_q holds the readback compare taken on entry to CHECK.
      CHECK: begin
        if (done_q) begin
          state_d = IDLE;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 3'd1;
          state_d = DRIVE;
        end else begin
          state_d = ERROR;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state they belong to and drop to 0 during clr.
  always_comb begin
    j_d      = '0;
    k_d      = '0;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    busy_d   = 1'b0;
    ready_d  = 1'b0;
    case (state_d)
      IDLE:  ready_d = 1'b1;
      DRIVE: begin
        busy_d = 1'b1;
        j_d    = exc_j;
        k_d    = exc_k;
      end
      STROBE: begin
        busy_d   = 1'b1;
        strobe_d = 1'b1;
        j_d      = j_q;
        k_d      = k_q;
      end
      SETTLE: busy_d = 1'b1;
      CHECK: begin
        busy_d = 1'b1;
        done_d = (bus.q_fb == tgt_r_d);
      end
      ERROR:   err_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      j_q      <= '0;
      k_q      <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      j_q      <= j_d;
      k_q      <= k_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.tgt_ready = ready_q;
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.jk_strobe = strobe_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Directed bench: two controllers (set/reset and toggle excitation) each
// driving a behavioural JK bank built from the JK characteristic equation.
module tb_jk_excite_ctrl;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  jk_excite_ctrl_if #(.WIDTH(4)) bus0 ();
  jk_excite_ctrl_if #(.WIDTH(4)) bus1 ();

  jk_excite_ctrl #(.WIDTH(4), .USE_TOGGLE(0), .SETTLE_CYC(2), .MAX_RETRY(2)) dut0 (
    .clk (clk), .clr (clr), .bus (bus0.slave));
  jk_excite_ctrl #(.WIDTH(4), .USE_TOGGLE(1), .SETTLE_CYC(2), .MAX_RETRY(2)) dut1 (
    .clk (clk), .clr (clr), .bus (bus1.slave));

  // Bank models: Q+ = J&~Q | ~K&Q on each strobed edge.
  logic [3:0] q0, q1, ld_val0, ld_val1;
  logic       ld0 = 1'b1, ld1 = 1'b1, stuck0 = 1'b0;
  always @(posedge clk) begin
    if (ld0) q0 <= ld_val0;
    else if (bus0.jk_strobe && !stuck0) q0 <= (bus0.j & ~q0) | (~bus0.k & q0);
  end
  always @(posedge clk) begin
    if (ld1) q1 <= ld_val1;
    else if (bus1.jk_strobe) q1 <= (bus1.j & ~q1) | (~bus1.k & q1);
  end
  assign bus0.q_fb = q0;
  assign bus1.q_fb = q1;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] outs0();
    return {bus0.tgt_ready, bus0.j, bus0.k, bus0.jk_strobe, bus0.done, bus0.err, bus0.busy};
  endfunction

  task automatic load0(input logic [3:0] v);
    ld0 = 1'b1; ld_val0 = v;
    @(negedge clk);
    ld0 = 1'b0;
  endtask

  // Offer one target to dut0 and watch 20 cycles; cycle 1 is the first
  // cycle after the accepting edge.
  task automatic txn0(input logic [3:0] tgt, output int done_at, output int n_strobe,
                      output logic [3:0] j1, output logic [3:0] k1);
    logic prev;
    int   b2b;
    prev = 1'b0; b2b = 0; done_at = -1; n_strobe = 0; j1 = '0; k1 = '0;
    bus0.tgt_valid = 1'b1; bus0.tgt_data = tgt;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus0.tgt_valid = 1'b0;
        j1 = bus0.j; k1 = bus0.k;
      end
      if (bus0.jk_strobe) n_strobe++;
      if (bus0.jk_strobe && prev) b2b++;
      prev = bus0.jk_strobe;
      if (bus0.done && done_at < 0) done_at = c;
    end
    chk("strobe_b2b", b2b, 0);
  endtask

  int         d_at, n_st;
  logic [3:0] jj, kk;
  logic       saw_done;

  initial begin
    bus0.tgt_valid = 1'b0; bus0.tgt_data = '0;
    bus1.tgt_valid = 1'b0; bus1.tgt_data = '0;
    ld_val0 = 4'b0000; ld_val1 = 4'b1100;

    // Reset: two clr cycles, everything registered to 0.
    @(negedge clk); @(negedge clk);
    chk("reset_outs0", outs0(), 13'h0);
    chk("reset_rdy1", bus1.tgt_ready, 1'b0);
    clr = 1'b0; ld0 = 1'b0; ld1 = 1'b0;
    @(negedge clk);
    chk("ready_after_clr", bus0.tgt_ready, 1'b1);

    // Set/reset excitation 0000 -> 1010.
    txn0(4'b1010, d_at, n_st, jj, kk);
    chk("t1_j", jj, 4'b1010);
    chk("t1_k", kk, 4'b0000);
    chk("t1_strobes", n_st, 1);
    chk("t1_done_at", d_at, 5);
    chk("t1_err", bus0.err, 1'b0);
    chk("t1_bank", q0, 4'b1010);

    // Toggle excitation 1100 -> 0110 on dut1.
    bus1.tgt_valid = 1'b1; bus1.tgt_data = 4'b0110;
    d_at = -1; n_st = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus1.tgt_valid = 1'b0;
        chk("t2_j", bus1.j, 4'b1010);
        chk("t2_k", bus1.k, 4'b1010);
      end
      if (bus1.jk_strobe) n_st++;
      if (bus1.done && d_at < 0) d_at = c;
    end
    chk("t2_strobes", n_st, 1);
    chk("t2_done_at", d_at, 5);
    chk("t2_bank", q1, 4'b0110);

    // Already matching: no strobe, done two cycles after accept.
    load0(4'b0101);
    txn0(4'b0101, d_at, n_st, jj, kk);
    chk("t3_strobes", n_st, 0);
    chk("t3_done_at", d_at, 2);

    // tgt_valid held across a transaction, data changed mid-flight.
    bus0.tgt_valid = 1'b1; bus0.tgt_data = 4'b0001;
    d_at = -1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 2) bus0.tgt_data = 4'b1000;
      if (c == 5) begin
        chk("t6_done1", bus0.done, 1'b1);
        chk("t6_rdy_in_done", bus0.tgt_ready, 1'b0);
      end
      if (c == 6) begin
        chk("t6_rdy_after", bus0.tgt_ready, 1'b1);
        chk("t6_bank1", q0, 4'b0001);
      end
      if (c == 7) begin
        bus0.tgt_valid = 1'b0;
        chk("t6_busy2", bus0.busy, 1'b1);
        chk("t6_j2", bus0.j, 4'b1000);
        chk("t6_k2", bus0.k, 4'b0001);
      end
      if (c > 5 && bus0.done && d_at < 0) d_at = c;
    end
    chk("t6_done2_at", d_at, 11);
    chk("t6_bank2", q0, 4'b1000);

    // Bank ignores strobes: three attempts, then sticky error.
    stuck0 = 1'b1;
    load0(4'b0000);
    txn0(4'b1111, d_at, n_st, jj, kk);
    chk("t4_strobes", n_st, 3);
    chk("t4_no_done", d_at, -1);
    bus0.tgt_valid = 1'b1; bus0.tgt_data = 4'b0001;
    for (int c = 0; c < 4; c++) @(negedge clk);
    chk("t4_err", bus0.err, 1'b1);
    chk("t4_rdy", bus0.tgt_ready, 1'b0);
    chk("t4_busy", bus0.busy, 1'b0);
    chk("t4_strobe", bus0.jk_strobe, 1'b0);
    bus0.tgt_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    chk("t4_clr_outs", outs0(), 13'h0);
    clr = 1'b0; stuck0 = 1'b0;
    @(negedge clk);
    chk("t4_rdy_after_clr", bus0.tgt_ready, 1'b1);

    // clr in the middle of SETTLE aborts cleanly.
    bus0.tgt_valid = 1'b1; bus0.tgt_data = 4'b1100;
    @(negedge clk); bus0.tgt_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_in_settle", bus0.busy, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    chk("t5_clr_outs", outs0(), 13'h0);
    clr = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus0.done) saw_done = 1'b1;
    end
    chk("t5_no_done", saw_done, 1'b0);
    chk("t5_idle_rdy", bus0.tgt_ready, 1'b1);
    chk("t5_bank", q0, 4'b1100);
    txn0(4'b0011, d_at, n_st, jj, kk);
    chk("t5_j", jj, 4'b0011);
    chk("t5_k", kk, 4'b1100);
    chk("t5_strobes", n_st, 1);
    chk("t5_done_at", d_at, 5);
    chk("t5_final", q0, 4'b0011);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
